data_mem_resp: RTL
==================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter LATENCY, default 4, cycles from request acceptance to Done; legal range 2..15.
REQ-002 Parameter DEPTH_W, default 8, log2 of word count (256 x 16-bit words).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 Addr  input  16  byte address; word index = Addr[DEPTH_W:1], upper bits ignored.
REQ-006 DataIn  input  16  write data.
REQ-007 Rd  input  1  read request.
REQ-008 Wr  input  1  write request.
REQ-009 DataOut  output  16  read data, valid only while Done=1.
REQ-010 Stall  output  1  request in progress; initiator holds Addr/DataIn/Rd/Wr stable.
REQ-011 Done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  one-cycle illegal-request flag (see REQ-025).

Function
REQ-013 FSM states SHALL be IDLE, BUSY, DONE.
REQ-014 IDLE: request = Rd^Wr; when high (and not rejected), Stall=1 combinationally that cycle, Addr/DataIn/op captured, counter loaded with LATENCY-2, next state BUSY.
REQ-015 IDLE with Rd=Wr=0: Stall=0, Done=0, remain IDLE.
REQ-016 BUSY: Stall=1; counter decrements each cycle; at counter=0, next state DONE.
REQ-017 Done SHALL rise exactly LATENCY cycles after the acceptance edge's cycle (acceptance cycle = cycle 0, Done in cycle LATENCY).
REQ-018 DONE: Stall=0, Done=1 for exactly one cycle, next state IDLE; Rd/Wr/Addr ignored in DONE.
REQ-019 Write: array word updated at the edge entering DONE, from captured DataIn/Addr; DataOut in DONE for write = written data.
REQ-020 Read: DataOut in DONE = array word at captured address; DataOut=0 outside DONE.
REQ-021 Input changes during BUSY SHALL not affect the in-flight operation (captured values used).
REQ-022 Back-to-back: new request presented in the DONE cycle is not accepted; accepted in the following IDLE cycle.
REQ-023 Read after write to same address SHALL return the new data.

Reset
REQ-024 rst low SHALL immediately force IDLE, counter=0, captured registers=0, Stall=0, Done=0, err=0, DataOut=0; array contents not reset; an in-flight write aborted by reset SHALL not modify the array.

Configuration
REQ-025 Macro DMEM_ERR_CHECK_EN defined: in IDLE, Rd&Wr=1 or (Rd^Wr with Addr[0]=1) SHALL assert err for one cycle, Stall=0, no state change, no array write.
REQ-026 Macro undefined: err tied 0; Rd&Wr=1 treated as no request; Addr[0] ignored.

Structure
REQ-027 Package dmem_pkg SHALL hold the state enum typedef, default LATENCY and DEPTH_W constants.
REQ-028 Storage SHALL be sub-module dmem_array (synchronous write, combinational read, DEPTH_W parameter); FSM/counter in data_mem_resp.

Verification
REQ-029 Reset mid-BUSY of Wr Addr=0x0010 Data=0xBEEF -> IDLE, Stall=0 immediately; later read 0x0010 does not return 0xBEEF.
REQ-030 Wr 0x0004=0x1234 then Rd 0x0004, LATENCY=4 -> Stall high cycles 0-3, Done cycle 4 each, DataOut=0x1234 on read Done.
REQ-031 Rd 0x0020 with Addr changed to 0x0040 during BUSY -> DataOut = word at 0x0020.
REQ-032 Request held through DONE cycle -> Done pulses once, re-accepted next cycle, second Done LATENCY cycles later.
REQ-033 DMEM_ERR_CHECK_EN: Rd Addr=0x0003 -> err=1 one cycle, Stall=0, Done never; Rd=Wr=1 -> err=1, array unchanged.
REQ-034 LATENCY=2: Rd -> Stall cycles 0-1, Done cycle 2.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data memory responder.
package dmem_pkg;
  localparam int unsigned LATENCY_DEF = 4;
  localparam int unsigned DEPTH_W_DEF = 8;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_e;
endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, combinational read, no reset on contents.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_W = DEPTH_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [DEPTH_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1 << DEPTH_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_resp.sv
// Fixed-latency data memory responder (IDLE/BUSY/DONE handshake).
// Optional illegal-request checking enabled by defining DMEM_ERR_CHECK_EN.
module data_mem_resp
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEF,
  parameter int unsigned DEPTH_W = DEPTH_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Rd,
  input  logic              Wr,
  output logic [DATA_W-1:0] DataOut,
  output logic              Stall,
  output logic              Done,
  output logic              err
);

  dmem_state_e         state;
  logic [CNT_W-1:0]    cnt;
  logic [DEPTH_W-1:0]  cap_idx;
  logic [DATA_W-1:0]   cap_data;
  logic                cap_wr;
  logic                req;
  logic                illegal;
  logic                accept;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_rdata;
  logic                addr_unused;

  assign req = Rd ^ Wr;

`ifdef DMEM_ERR_CHECK_EN
  assign illegal = (Rd & Wr) | (req & Addr[0]);
  assign err     = rst & (state == IDLE) & illegal;
`else
  assign illegal = 1'b0;
  assign err     = 1'b0;
`endif

  assign addr_unused = ^{Addr[DATA_W-1:DEPTH_W+1], Addr[0]};

  assign accept = (state == IDLE) & req & ~illegal;
  // Gated by rst so Stall drops the instant reset asserts, even with a request held.
  assign Stall  = rst & (accept | (state == BUSY));
  assign Done   = (state == DONE);

  // Array write lands on the edge that enters DONE; reset forces IDLE and kills it.
  assign mem_we = (state == BUSY) & (cnt == '0) & cap_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_idx  <= '0;
      cap_data <= '0;
      cap_wr   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            cap_idx  <= Addr[DEPTH_W:1];
            cap_data <= DataIn;
            cap_wr   <= Wr;
            cnt      <= CNT_W'(LATENCY - 2);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  dmem_array #(.DEPTH_W(DEPTH_W)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (cap_idx),
    .wdata (cap_data),
    .rdata (mem_rdata)
  );

  assign DataOut = Done ? mem_rdata : '0;

endmodule
